// File: rtl/serial_rx_pkg.sv
// Shared types and default constants for the serial receive path.
package serial_rx_pkg;

   localparam int CLKS_PER_BIT_DEF = 16;
   localparam int WIDTH_DEF        = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

endpackage

// File: rtl/serial_byte_rx_if.sv
// Line input and received-word outputs of the serial receiver.
// master: the receiver itself; slave: line driver / word consumer.
interface serial_byte_rx_if
   import serial_rx_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) ();

   logic             rx_in;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             parity_err;
   logic             frame_err;
   logic             busy;

   modport master (
      input  rx_in,
      output data_out,
      output data_valid,
      output parity_err,
      output frame_err,
      output busy
   );

   modport slave (
      output rx_in,
      input  data_out,
      input  data_valid,
      input  parity_err,
      input  frame_err,
      input  busy
   );

endinterface

// File: rtl/serial_byte_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // next values: shift the input through the two stages
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // synchronizer flops, reset to the line's idle level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/serial_byte_rx.sv
// Oversampled LSB-first serial receiver with start validation,
// optional parity check and framing-error detection.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | counting to mid start bit, then confirm it is still low
// DATA   | sampling WIDTH data bits at mid-bit
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, publishing the result
// BREAK  | stop bit was low; wait for the line to return high
module serial_byte_rx
   import serial_rx_pkg::*;
#(
   parameter int WIDTH        = WIDTH_DEF,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst,
   serial_byte_rx_if.master  bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0] RELOAD_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] RELOAD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] LAST_BIT    = BW'(WIDTH - 1);
   localparam logic          PAR_EN      = (PARITY_EN != 0);
   localparam logic          ODD_BIT     = (PARITY_ODD != 0);

   logic             rx_s;
   rx_state_t        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             par_q, par_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             rx_prev_q, rx_prev_d;
   logic             tick;
   logic             fall;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rx_in),
      .q   (rx_s)
   );

   assign tick = (cnt_q == '0);
   assign fall = rx_prev_q & ~rx_s;

   // next-state, counters, shifter and result pulses
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      rx_prev_d = rx_s;

      unique case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               cnt_d   = RELOAD_HALF;
            end
         end
         START: begin
            if (tick) begin
               if (!rx_s) begin
                  state_d = DATA;
                  cnt_d   = RELOAD_FULL;
                  bit_d   = '0;
                  par_d   = 1'b0;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DATA: begin
            if (tick) begin
               shift_d            = shift_q >> 1;
               shift_d[WIDTH-1]   = rx_s;
               par_d              = par_q ^ rx_s;
               cnt_d              = RELOAD_FULL;
               if (bit_q == LAST_BIT) begin
                  state_d = PAR_EN ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         PARITY: begin
            if (tick) begin
               par_d   = par_q ^ rx_s;
               state_d = STOP;
               cnt_d   = RELOAD_FULL;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         STOP: begin
            if (tick) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  perr_d  = PAR_EN && (par_q != ODD_BIT);
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         BREAK: begin
            if (rx_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // state and datapath registers; reset discards any frame in progress
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         rx_prev_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         rx_prev_q <= rx_prev_d;
      end
   end

   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
   assign bus.busy       = (state_q != IDLE);

endmodule
